// File: rtl/aes_pkg.sv
// Shared AES definitions: the state type, the field reduction constant
// and the GF(2^8) helpers used by the round datapath.
package aes_pkg;

    // Full 128-bit AES state. Byte n lives at [127-8n -: 8] and column c
    // at [127-32c -: 32], with row 0 in the most significant byte of a column.
    typedef logic [127:0] state_t;

    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
    localparam logic [7:0] AES_POLY = 8'h1B;

    // Multiply by x (i.e. by 2) in GF(2^8), reducing by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // MixColumns on one 32-bit column, rows 0..3 from MSB to LSB.
    // Multiplying by 3 is written as xtime(a) ^ a, so only xtime is needed.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box as a flat 256-entry lookup table (purely combinational).
module aes_sbox (
    input  logic [7:0] plain_byte,
    output logic [7:0] sub_byte
);

    // Entry 0x00 sits in the top byte, entry 0xFF in the bottom byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry k starts at bit (255-k)*8; 255-k is simply the bitwise inverse of k.
    assign sub_byte = SBOX_TABLE[{~plain_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes_round_datapath.sv
// One AES-128 encryption round without AddRoundKey:
// SubBytes -> ShiftRows -> MixColumns (MixColumns skipped on the final round).
// The transform is combinational; only the result is registered.
module aes_round_datapath
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_final,
    input  logic [127:0] in_state,
    output logic         out_valid,
    output logic [127:0] out_state
);

    state_t sub_state;
    state_t shift_state;
    state_t mix_state;
    state_t next_state;

    // SubBytes: one S-box per state byte.
    for (genvar n = 0; n < 16; n++) begin : g_sub_bytes
        aes_sbox u_sbox (
            .plain_byte (in_state[127-8*n -: 8]),
            .sub_byte   (sub_state[127-8*n -: 8])
        );
    end

    // ShiftRows: row r of column c takes row r of column (c+r) mod 4.
    for (genvar c = 0; c < 4; c++) begin : g_shift_col
        for (genvar r = 0; r < 4; r++) begin : g_shift_row
            assign shift_state[127-8*(4*c+r) -: 8] =
                sub_state[127-8*(4*((c+r)%4)+r) -: 8];
        end
    end

    // MixColumns: each column mixed independently.
    for (genvar c = 0; c < 4; c++) begin : g_mix_col
        assign mix_state[127-32*c -: 32] = mix_col(shift_state[127-32*c -: 32]);
    end

    // The final round omits MixColumns.
    assign next_state = in_final ? shift_state : mix_state;

    // Output register: capture a new result on valid input, otherwise hold it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_state <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_state <= next_state;
            end
        end
    end

endmodule

// File: tb/tb_aes_round_datapath.sv
// Self-checking bench for aes_round_datapath: directed FIPS-197 vectors,
// S-box spot checks, streaming/hold/reset behaviour and a random sweep
// against an independent arithmetic model of the round.
module tb_aes_round_datapath;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_final;
    logic [127:0] in_state;
    logic         out_valid;
    logic [127:0] out_state;

    int total_checks;
    int bad_checks;

    logic [7:0] sbox_ref [256];

    aes_round_datapath dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_final  (in_final),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_state (out_state)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1B;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // S-box derived from first principles: inverse (a^254) then affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] s;
        inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    // Reference round built from byte arrays and general field multiplies.
    function automatic logic [127:0] ref_round(input logic [127:0] st, input logic fin);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   m [16];
        logic [127:0] res;
        for (int n = 0; n < 16; n++) s[n] = sbox_ref[st[127-8*n -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = s[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            m[4*c+0] = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
            m[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
            m[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
            m[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
        end
        res = '0;
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = fin ? t[n] : m[n];
        return res;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then step past the rising edge.
    task automatic applyStimulus(input logic r, input logic v, input logic f,
                                 input logic [127:0] st);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_final = f;
        in_state = st;
        @(posedge clk);
        #1;
    endtask

    logic [127:0] exp_state;
    logic         exp_valid;
    logic [127:0] rnd_state;
    logic         rnd_valid;
    logic         rnd_final;
    logic [7:0]   spot_in  [4];
    logic [7:0]   spot_out [4];

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_final = 1'b0;
        in_state = '0;
        for (int k = 0; k < 256; k++) sbox_ref[k] = sbox_calc(8'(k));

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("reset_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("reset_state", out_state, 128'd0);

        // S-box spot checks with uniform states on the final round
        spot_in[0] = 8'h00; spot_out[0] = 8'h63;
        spot_in[1] = 8'h53; spot_out[1] = 8'hED;
        spot_in[2] = 8'hFF; spot_out[2] = 8'h16;
        spot_in[3] = 8'h01; spot_out[3] = 8'h7C;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, {16{spot_in[i]}});
            checkOutput("sbox_valid", {127'd0, out_valid}, 128'd1);
            checkOutput("sbox_spot", out_state, {16{spot_out[i]}});
        end

        // FIPS-197 appendix B, round 1
        applyStimulus(1'b0, 1'b1, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        checkOutput("fips_b_r1", out_state, 128'h046681e5e0cb199a48f8d37a2806264c);
        checkOutput("fips_b_col0", {96'd0, out_state[127:96]}, {96'd0, 32'h046681e5});

        // FIPS-197 C.1 round 1, full and final-round forms
        applyStimulus(1'b0, 1'b1, 1'b0, 128'h00102030405060708090a0b0c0d0e0f0);
        checkOutput("fips_c1_r1", out_state, 128'h5f72641557f5bc92f7be3b291db9f91a);
        applyStimulus(1'b0, 1'b1, 1'b1, 128'h00102030405060708090a0b0c0d0e0f0);
        checkOutput("fips_c1_final", out_state, 128'h6353e08c0960e104cd70b751bacad0e7);

        // Streaming: three back-to-back inputs, then a gap that must hold
        applyStimulus(1'b0, 1'b1, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        checkOutput("stream0", out_state, 128'h046681e5e0cb199a48f8d37a2806264c);
        applyStimulus(1'b0, 1'b1, 1'b1, 128'h00102030405060708090a0b0c0d0e0f0);
        checkOutput("stream1", out_state, 128'h6353e08c0960e104cd70b751bacad0e7);
        applyStimulus(1'b0, 1'b1, 1'b0, 128'h00102030405060708090a0b0c0d0e0f0);
        checkOutput("stream2_valid", {127'd0, out_valid}, 128'd1);
        checkOutput("stream2", out_state, 128'h5f72641557f5bc92f7be3b291db9f91a);
        applyStimulus(1'b0, 1'b0, 1'b1, 128'hffffffffffffffffffffffffffffffff);
        checkOutput("gap_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("gap_hold", out_state, 128'h5f72641557f5bc92f7be3b291db9f91a);

        // Reset wins over a valid input on the same edge
        applyStimulus(1'b1, 1'b1, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        checkOutput("rst_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("rst_state", out_state, 128'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        checkOutput("post_rst_valid", {127'd0, out_valid}, 128'd1);
        checkOutput("post_rst", out_state, 128'h046681e5e0cb199a48f8d37a2806264c);

        // Random sweep with random valid gaps against the reference model
        exp_state = out_state;
        for (int i = 0; i < 1000; i++) begin
            rnd_state = {$urandom, $urandom, $urandom, $urandom};
            rnd_final = 1'($urandom_range(0, 1));
            rnd_valid = ($urandom_range(0, 3) != 0);
            applyStimulus(1'b0, rnd_valid, rnd_final, rnd_state);
            exp_valid = rnd_valid;
            if (rnd_valid) exp_state = ref_round(rnd_state, rnd_final);
            checkOutput("rand_valid", {127'd0, out_valid}, {127'd0, exp_valid});
            checkOutput("rand_state", out_state, exp_state);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
